// File: rtl/pwm_generate.sv
// Frame-based PWM transmitter: pulse high-time in units of CLKS_PER_UNIT clocks,
// frame length PERIOD_UNITS units, new values latched only at frame boundaries.
//
// state  | meaning
// S_IDLE | no frame running, counters and output held at 0
// S_RUN  | frame in progress, busy=1
module pwm_generate #(
    parameter int WIDTH         = 16,
    parameter int CLKS_PER_UNIT = 100,
    parameter int PERIOD_UNITS  = 60000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             value_valid,
    input  logic [WIDTH-1:0] value,
    output logic             value_ready,
    output logic             pwm_out,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] PRE_LAST   = WIDTH'(CLKS_PER_UNIT - 1);
    localparam logic [WIDTH-1:0] UNIT_LAST  = WIDTH'(PERIOD_UNITS - 1);
    localparam logic [WIDTH-1:0] UNIT_LIMIT = WIDTH'(PERIOD_UNITS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] unit_q, unit_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic             pwm_q, pwm_d;

    logic frame_last;
    logic frame_start;
    logic xfer;

    // A full-frame pulse would leave no low unit, so clamp to one unit short.
    function automatic logic [WIDTH-1:0] clamp_units(input logic [WIDTH-1:0] v);
        return (v >= UNIT_LIMIT) ? UNIT_LAST : v;
    endfunction

    assign frame_last  = (state_q == S_RUN) && (presc_q == PRE_LAST) && (unit_q == UNIT_LAST);
    assign frame_start = enable && ((state_q == S_IDLE) || frame_last);
    assign xfer        = value_valid && !full_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            unit_q   <= '0;
            active_q <= '0;
            hold_q   <= '0;
            full_q   <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            unit_q   <= unit_d;
            active_q <= active_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            pwm_q    <= pwm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (frame_last && !enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d  = presc_q;
        unit_d   = unit_q;
        active_d = active_q;
        hold_d   = hold_q;
        full_d   = full_q;
        if (frame_start) begin
            presc_d = '0;
            unit_d  = '0;
            if (full_q) begin
                active_d = clamp_units(hold_q);
                full_d   = 1'b0;
            end else if (xfer) begin
                active_d = clamp_units(value);
            end
        end else begin
            if (xfer) begin
                hold_d = value;
                full_d = 1'b1;
            end
            if (state_q == S_RUN) begin
                if (frame_last) begin
                    presc_d = '0;
                    unit_d  = '0;
                end else if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    unit_d  = unit_q + 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end
        // High while the unit about to be entered is below the active width.
        pwm_d = (state_d == S_RUN) && (unit_d < active_d);
    end

    always_comb begin
        busy        = (state_q == S_RUN);
        frame_done  = frame_last;
        value_ready = !full_q;
        pwm_out     = pwm_q;
    end

endmodule

// File: tb/tb_pwm_generate.sv
// Scoreboard bench for pwm_generate: a frame-level reference model predicts
// per-cycle outputs and per-frame high time; a monitor compares at negedges.
module tb_pwm_generate;

    localparam int W     = 16;
    localparam int CPU   = 2;
    localparam int PU    = 10;
    localparam int FRAME = CPU * PU;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         value_valid = 1'b0;
    logic [W-1:0] value = '0;
    logic         value_ready;
    logic         pwm_out;
    logic         frame_done;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    int exp_q[$];

    bit m_run = 1'b0;
    bit m_full = 1'b0;
    int m_k = 0;
    int m_hold = 0;
    int m_active = 0;

    pwm_generate #(
        .WIDTH(W),
        .CLKS_PER_UNIT(CPU),
        .PERIOD_UNITS(PU)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .value_valid(value_valid),
        .value(value),
        .value_ready(value_ready),
        .pwm_out(pwm_out),
        .frame_done(frame_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v >= PU) ? PU - 1 : v;
    endfunction

    // Reference model: one frame is FRAME clocks indexed by m_k; the high time
    // of a frame is active*CPU clocks from its start.
    task automatic model_step();
        bit xfer;
        bit start;
        if (!reset) begin
            m_run    = 1'b0;
            m_full   = 1'b0;
            m_k      = 0;
            m_hold   = 0;
            m_active = 0;
            exp_q.delete();
        end else begin
            xfer  = value_valid && !m_full;
            start = enable && (!m_run || m_k == FRAME - 1);
            if (start) begin
                if (m_full) begin
                    m_active = clampv(m_hold);
                    m_full   = 1'b0;
                end else if (xfer) begin
                    m_active = clampv(int'(value));
                end
                m_run = 1'b1;
                m_k   = 0;
                exp_q.push_back(m_active * CPU);
            end else begin
                if (xfer) begin
                    m_hold = int'(value);
                    m_full = 1'b1;
                end
                if (m_run) begin
                    if (m_k == FRAME - 1) begin
                        m_run = 1'b0;
                        m_k   = 0;
                    end else begin
                        m_k++;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // Monitor: per-cycle outputs against the model, per-frame high time against the queue.
    initial begin
        int fcyc;
        int fhigh;
        int e;
        fcyc  = 0;
        fhigh = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_pwm_out", int'(pwm_out), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_frame_done", int'(frame_done), 0);
                chk("rst_value_ready", int'(value_ready), 1);
                fcyc  = 0;
                fhigh = 0;
            end else begin
                chk("pwm_out", int'(pwm_out), int'(m_run && (m_k < m_active * CPU)));
                chk("busy", int'(busy), int'(m_run));
                chk("frame_done", int'(frame_done), int'(m_run && (m_k == FRAME - 1)));
                chk("value_ready", int'(value_ready), int'(!m_full));
                if (busy) begin
                    fcyc++;
                    if (pwm_out) fhigh++;
                end
                if (frame_done) begin
                    if (exp_q.size() == 0) begin
                        chk("frame_queue_nonempty", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_high_clocks", fhigh, e);
                        chk("frame_length", fcyc, FRAME);
                    end
                    fcyc  = 0;
                    fhigh = 0;
                end
            end
        end
    end

    task automatic offer(input int v, input int max_cyc, input bit must);
        bit done;
        done        = 1'b0;
        value_valid = 1'b1;
        value       = W'(v);
        for (int i = 0; i < max_cyc && !done; i++) begin
            if (value_ready) done = 1'b1;
            @(negedge clk);
        end
        value_valid = 1'b0;
        if (must) chk("offer_accepted", int'(done), 1);
    endtask

    task automatic wait_fd(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("wait_frame_done", int'(seen), 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit idle;
        idle = !busy;
        for (int i = 0; i < max_cyc && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk("wait_idle", int'(idle), 1);
    endtask

    initial begin
        bit seen;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // value 3 loaded in IDLE, then two back-to-back frames
        offer(3, 4, 1'b1);
        enable = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        // zero width, then over-range value clamped
        offer(0, 2 * FRAME, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
        offer(15, 2 * FRAME, 1'b1);
        repeat (2 * FRAME) @(negedge clk);

        // active=3, new value mid-frame, second value must stall
        offer(3, 2 * FRAME, 1'b1);
        wait_fd(3 * FRAME);
        wait_fd(3 * FRAME);
        repeat (3) @(negedge clk);
        offer(5, 2, 1'b1);
        offer(7, 5, 1'b0);
        repeat (3 * FRAME) @(negedge clk);

        // enable dropped mid-frame
        wait_fd(3 * FRAME);
        repeat (8) @(negedge clk);
        enable = 1'b0;
        wait_idle(2 * FRAME);
        repeat (5) @(negedge clk);

        // asynchronous reset in the middle of a pulse
        offer(3, 4, 1'b1);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (pwm_out) seen = 1'b1;
        end
        chk("pulse_started", int'(seen), 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pwm_out", int'(pwm_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_value_ready", int'(value_ready), 1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (FRAME) @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            value_valid = 1'($urandom_range(0, 1));
            value       = W'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) enable = ~enable;
        end

        value_valid = 1'b0;
        enable      = 1'b0;
        @(negedge clk);
        wait_idle(3 * FRAME);
        @(negedge clk);
        chk("frames_outstanding", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_generate.md
Name: pwm_generate

Overview:
- Frame-based PWM transmitter. Encodes a 16-bit value as a pulse high-time in units of CLKS_PER_UNIT clocks, inside a fixed frame of PERIOD_UNITS units.
- It is the transmit end of the pulse-width link that pwm_measure receives. It drives sensor-emulation, loopback and actuator paths.
- New values are accepted through a one-deep valid/ready holding register. They take effect only at frame boundaries, so a pulse is never truncated or glitched.

Parameters:
- WIDTH, 16, width of value and of the unit counter.
- CLKS_PER_UNIT, 100, clocks per pulse unit (1 us at 100 MHz). Must be >= 1.
- PERIOD_UNITS, 60000, frame length in units. Must be >= 2 and < 2^WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- enable  input  1  1 = start/continue frames; 0 = stop after the current frame.
- value_valid  input  1  value is offered this cycle.
- value  input  WIDTH  requested high-time in units.
- value_ready  output  1  holding register empty; a transfer occurs on valid && ready.
- pwm_out  output  1  registered PWM output.
- frame_done  output  1  one-clock pulse on the last clock of each frame.
- busy  output  1  1 while a frame is in progress.

Behaviour:
- Reset (reset=0), asynchronous:
  - pwm_out=0, frame_done=0, busy=0, value_ready=1.
  - Holding register empty; active value=0.
  - Prescaler and unit counter = 0; state = IDLE.
  - Applies immediately, including mid-pulse.
- States:
  - IDLE: busy=0, pwm_out=0, counters held at 0.
  - RUN: busy=1.
- IDLE -> RUN: on the first edge with enable=1. That edge is a frame-start edge.
- Frame-start edge, value selection (in priority order):
  1. Holding register full: active <= held value; holding register emptied.
  2. Otherwise, valid && ready on this same edge: active <= value (bypass).
  3. Otherwise: active is unchanged.
- Frame-start edge, output: pwm_out <= (clamped active != 0), in the same edge.
- Clamping: active values >= PERIOD_UNITS are used as PERIOD_UNITS-1, which guarantees at least one low unit per frame. The clamp is applied when the value is loaded into active.
- Counting:
  - The prescaler counts 0..CLKS_PER_UNIT-1.
  - On prescaler wrap, the unit counter increments, 0..PERIOD_UNITS-1.
  - pwm_out is high for exactly active*CLKS_PER_UNIT clocks from the frame-start edge, then low for the remainder of the frame.
- Frame length: exactly PERIOD_UNITS*CLKS_PER_UNIT clocks. frame_done=1 on the final clock, i.e. prescaler=CLKS_PER_UNIT-1 and unit=PERIOD_UNITS-1.
- End of frame:
  - enable=1 on the edge after frame_done: that edge is the next frame-start, with no gap clock.
  - enable=0 on that edge: go to IDLE with pwm_out=0.
  - enable deasserted mid-frame has no effect until the frame ends.
- Holding register:
  - value_ready = !full.
  - A transfer on a non-frame-start edge fills it.
  - A transfer while in IDLE also fills it; that value is consumed at the next frame-start.
  - The held value is never overwritten. The producer stalls until frame start.
- Value 0: pwm_out stays 0 for the whole frame. frame_done still pulses.
- Widths: counters are WIDTH bits. The unit count vs active comparison is unsigned.
- Latency: a value accepted at or before a frame-start edge appears on pwm_out at that edge. A value accepted mid-frame appears at the next frame-start.

Test Plan:
- Use CLKS_PER_UNIT=2, PERIOD_UNITS=10 throughout.
- Reset: hold reset=0 for 10 clocks -> pwm_out=0, busy=0, frame_done=0, value_ready=1. Then release.
- Load value 3 in IDLE, then set enable=1 -> pwm_out high 6 clocks, low 14. frame_done pulses on clock 20. The next frame repeats immediately with high=6.
- Value 0 -> pwm_out stays 0 for all 20 clocks. frame_done still pulses on clock 20. busy=1 throughout.
- Value 15 -> clamped to 9 -> pwm_out high 18 clocks, low 2 clocks per frame.
- Active=3; offer 5 at clock 4 of a frame -> current pulse still 6 clocks. value_ready=0 until the next frame-start. The next frame's pulse is 10 clocks. A second value offered meanwhile is not accepted.
- Drop enable at clock 8 of a frame -> the frame completes (20 clocks, frame_done pulses), then busy=0 and pwm_out=0.
- Assert reset at clock 3 of a high pulse -> pwm_out=0 immediately (asynchronous). After release, value_ready=1 and no pulse occurs until enable and a new frame start.
